// File: rtl/pong_hcount.sv
// Horizontal counter of the pong sync chain, counting 0..H_TOTAL-1
// on falling edges of the sampled TTL pixel clock, with line decodes.
//
// Ports:
//   CLK_DRV  - system clock, all state updates on its rising edge
//   RESET_N  - synchronous active-low reset
//   CLK      - TTL pixel clock level, sampled; counter steps on its fall
//   H        - 9-bit horizontal count
//   HRESET   - high while H is the last count of the line
//   HRESET_N - inverse of HRESET
//   HBLANK   - high for H in 0..HBLANK_END-1
//   HSYNC    - high for H in HSYNC_START..HSYNC_END-1
//   HTICK    - one-cycle strobe in the cycle after H advanced
module pong_hcount #(
   parameter int H_TOTAL     = 455,
   parameter int HBLANK_END  = 80,
   parameter int HSYNC_START = 32,
   parameter int HSYNC_END   = 64
) (
   input  logic       CLK_DRV,
   input  logic       RESET_N,
   input  logic       CLK,
   output logic [8:0] H,
   output logic       HRESET,
   output logic       HRESET_N,
   output logic       HBLANK,
   output logic       HSYNC,
   output logic       HTICK
);

   if (H_TOTAL < 2 || H_TOTAL > 512 ||
       HBLANK_END >= H_TOTAL ||
       HSYNC_START >= HSYNC_END ||
       HSYNC_END > HBLANK_END) begin : g_bad_params
      $error("pong_hcount: illegal parameter set");
   end

   localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
   localparam logic [8:0] HB_END  = 9'(HBLANK_END);
   localparam logic [8:0] HS_BEG  = 9'(HSYNC_START);
   localparam logic [8:0] HS_END  = 9'(HSYNC_END);

   logic [8:0] h_q, h_d;
   logic       clk_prev_q, clk_prev_d;
   logic       htick_q, htick_d;
   logic       hreset_q, hreset_d;
   logic       hreset_n_q, hreset_n_d;
   logic       hblank_q, hblank_d;
   logic       hsync_q, hsync_d;

   logic       tick;
   logic [8:0] h_next;

   // Decodes look at the value H is about to take so they switch
   // on the same edge as H itself.
   always_comb begin
      tick       = clk_prev_q & ~CLK;
      h_next     = (h_q == H_LAST) ? 9'd0 : h_q + 9'd1;
      h_d        = h_q;
      clk_prev_d = CLK;
      htick_d    = tick;
      hreset_d   = hreset_q;
      hreset_n_d = hreset_n_q;
      hblank_d   = hblank_q;
      hsync_d    = hsync_q;
      if (tick) begin
         h_d        = h_next;
         hreset_d   = (h_next == H_LAST);
         hreset_n_d = (h_next != H_LAST);
         if (h_next == 9'd0) begin
            hblank_d = 1'b1;
         end else if (h_next == HB_END) begin
            hblank_d = 1'b0;
         end
         if (h_next == HS_BEG) begin
            hsync_d = 1'b1;
         end else if (h_next == HS_END) begin
            hsync_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK_DRV) begin
      if (!RESET_N) begin
         h_q        <= 9'd0;
         clk_prev_q <= 1'b0;
         htick_q    <= 1'b0;
         hreset_q   <= 1'b0;
         hreset_n_q <= 1'b1;
         hblank_q   <= 1'b1;
         hsync_q    <= 1'b0;
      end else begin
         h_q        <= h_d;
         clk_prev_q <= clk_prev_d;
         htick_q    <= htick_d;
         hreset_q   <= hreset_d;
         hreset_n_q <= hreset_n_d;
         hblank_q   <= hblank_d;
         hsync_q    <= hsync_d;
      end
   end

   assign H        = h_q;
   assign HRESET   = hreset_q;
   assign HRESET_N = hreset_n_q;
   assign HBLANK   = hblank_q;
   assign HSYNC    = hsync_q;
   assign HTICK    = htick_q;

endmodule

// File: tb/tb_pong_hcount.sv
// Bench for pong_hcount: default 455-count line plus a 16-count
// instance, checked every cycle against an arithmetic model.
module tb_pong_hcount;

   logic       CLK_DRV;
   logic       RESET_N;
   logic       CLK;

   logic [8:0] h_b, h_s;
   logic       hr_b, hrn_b, hbl_b, hs_b, ht_b;
   logic       hr_s, hrn_s, hbl_s, hs_s, ht_s;

   int n_cmp;
   int n_bad;
   int tick_cnt;

   pong_hcount u_big (
      .CLK_DRV  (CLK_DRV),
      .RESET_N  (RESET_N),
      .CLK      (CLK),
      .H        (h_b),
      .HRESET   (hr_b),
      .HRESET_N (hrn_b),
      .HBLANK   (hbl_b),
      .HSYNC    (hs_b),
      .HTICK    (ht_b)
   );

   pong_hcount #(
      .H_TOTAL     (16),
      .HBLANK_END  (8),
      .HSYNC_START (2),
      .HSYNC_END   (4)
   ) u_small (
      .CLK_DRV  (CLK_DRV),
      .RESET_N  (RESET_N),
      .CLK      (CLK),
      .H        (h_s),
      .HRESET   (hr_s),
      .HRESET_N (hrn_s),
      .HBLANK   (hbl_s),
      .HSYNC    (hs_s),
      .HTICK    (ht_s)
   );

   initial CLK_DRV = 1'b0;
   always #5 CLK_DRV = ~CLK_DRV;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: count of falling CLK levels seen since reset, modulo the
   // line length; every decode is a plain range test on that count.
   int  m_hb, m_hs;
   bit  m_prev, m_tick;

   always @(posedge CLK_DRV) begin
      bit r, c;
      r = RESET_N;
      c = CLK;
      if (!r) begin
         m_hb   = 0;
         m_hs   = 0;
         m_prev = 0;
         m_tick = 0;
      end else begin
         m_tick = m_prev && !c;
         if (m_tick) begin
            m_hb = (m_hb + 1) % 455;
            m_hs = (m_hs + 1) % 16;
         end
         m_prev = c;
      end
      #1;
      chk("big_H", int'(h_b), m_hb);
      chk("big_HRESET", int'(hr_b), int'(m_hb == 454));
      chk("big_HRESET_N", int'(hrn_b), int'(m_hb != 454));
      chk("big_HBLANK", int'(hbl_b), int'(m_hb < 80));
      chk("big_HSYNC", int'(hs_b), int'(m_hb >= 32 && m_hb < 64));
      chk("big_HTICK", int'(ht_b), int'(m_tick));
      chk("small_H", int'(h_s), m_hs);
      chk("small_HRESET", int'(hr_s), int'(m_hs == 15));
      chk("small_HRESET_N", int'(hrn_s), int'(m_hs != 15));
      chk("small_HBLANK", int'(hbl_s), int'(m_hs < 8));
      chk("small_HSYNC", int'(hs_s), int'(m_hs >= 2 && m_hs < 4));
      chk("small_HTICK", int'(ht_s), int'(m_tick));
   end

   task automatic step(input bit c, input bit r);
      @(negedge CLK_DRV);
      CLK     = c;
      RESET_N = r;
      @(posedge CLK_DRV);
      #2;
      if (ht_b) tick_cnt++;
   endtask

   task automatic falls(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b1);
         step(1'b0, 1'b1);
      end
   endtask

   initial begin
      int ns, nb;
      n_cmp    = 0;
      n_bad    = 0;
      tick_cnt = 0;
      RESET_N  = 1'b0;
      CLK      = 1'b0;

      // reset held with CLK toggling
      for (int i = 0; i < 4; i++) begin
         step(i[0] ? 1'b0 : 1'b1, 1'b0);
         chk("rst_H", int'(h_b), 0);
         chk("rst_HBLANK", int'(hbl_b), 1);
         chk("rst_HSYNC", int'(hs_b), 0);
         chk("rst_HRESET_N", int'(hrn_b), 1);
         chk("rst_HTICK", int'(ht_b), 0);
      end

      // ten falling edges
      tick_cnt = 0;
      falls(10);
      chk("count_H", int'(h_b), 10);
      chk("count_ticks", tick_cnt, 10);

      // run to the last count, then wrap
      falls(444);
      chk("wrap_H454", int'(h_b), 454);
      chk("wrap_HRESET", int'(hr_b), 1);
      chk("wrap_HRESET_N", int'(hrn_b), 0);
      falls(1);
      chk("wrap_H0", int'(h_b), 0);
      chk("wrap_HRESET0", int'(hr_b), 0);
      chk("wrap_HBLANK", int'(hbl_b), 1);

      // one full line of decodes
      ns = 0;
      nb = 0;
      for (int i = 0; i < 455; i++) begin
         step(1'b1, 1'b1);
         step(1'b0, 1'b1);
         if (ht_b && hs_b) ns++;
         if (ht_b && hbl_b) nb++;
      end
      chk("line_hsync_ticks", ns, 32);
      chk("line_hblank_ticks", nb, 80);
      chk("line_end_H", int'(h_b), 0);

      // reset at H=200 on the same edge as a tick
      falls(200);
      chk("mid_H200", int'(h_b), 200);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      chk("mid_rst_H", int'(h_b), 0);
      chk("mid_rst_HTICK", int'(ht_b), 0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("mid_resume_H", int'(h_b), 1);
      chk("mid_resume_HTICK", int'(ht_b), 1);

      // release reset while CLK is already low
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1);
         chk("low_rel_H", int'(h_b), 0);
         chk("low_rel_HTICK", int'(ht_b), 0);
      end
      step(1'b1, 1'b1);
      chk("low_rise_H", int'(h_b), 0);
      step(1'b0, 1'b1);
      chk("low_fall_H", int'(h_b), 1);

      // mod-16 golden check on the short line
      falls(40);
      chk("big_H41", int'(h_b), 41);
      chk("small_H_mod16", int'(h_s), 9);

      step(1'b1, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
